// File: rtl/nrisk_pkg.sv
// rtl/nrisk_pkg.sv - shared field layout, opcode constants and fetch FSM encoding
package nrisk_pkg;

  localparam int OPCODE_MSB = 7;
  localparam int OPCODE_LSB = 5;
  localparam int REG_MSB    = 4;
  localparam int REG_LSB    = 3;
  localparam int IMM_MSB    = 2;
  localparam int IMM_LSB    = 0;

  // Opcode meanings are owned by the execute stage; only HALT matters here.
  localparam logic [2:0] OP_LDI  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_LD   = 3'b101;
  localparam logic [2:0] OP_ST   = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  localparam logic [7:0] HALT = 8'hFF;

  typedef enum logic [1:0] {
    BUSCA   = 2'd0,
    ENTREGA = 2'd1,
    PARADO  = 2'd2
  } estado_t;

  function automatic logic is_halt(input logic [7:0] word);
    return word == HALT;
  endfunction

endpackage

// File: rtl/instr_fetch_decode.sv
// rtl/instr_fetch_decode.sv - program counter, instruction fetch and field decode
module instr_fetch_decode
  import nrisk_pkg::*;
#(
  parameter int                  LARGURA_PC = 8,
  parameter logic [LARGURA_PC-1:0] PC_RESET = 8'h00
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  memReq,
  output logic [LARGURA_PC-1:0] memEndereco,
  input  logic [7:0]            memDado,
  input  logic                  memPronto,
  output logic                  saidaValida,
  input  logic                  saidaPronta,
  output logic [2:0]            opcode,
  output logic [1:0]            regDestino,
  output logic [2:0]            imediato,
  output logic [LARGURA_PC-1:0] pcInstrucao,
  input  logic                  desvio,
  input  logic [LARGURA_PC-1:0] alvoDesvio
);

  estado_t               estado;
  logic [LARGURA_PC-1:0] pc;
  logic [7:0]            ir;

  assign memEndereco = pc;
  assign opcode      = ir[OPCODE_MSB:OPCODE_LSB];
  assign regDestino  = ir[REG_MSB:REG_LSB];
  assign imediato    = ir[IMM_MSB:IMM_LSB];

  // memReq doubles as the "request really issued" qualifier, so a memPronto
  // seen in the cycle reset is released cannot be taken as a fetch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= BUSCA;
      pc          <= PC_RESET;
      ir          <= '0;
      pcInstrucao <= '0;
      memReq      <= 1'b0;
      saidaValida <= 1'b0;
    end else if (desvio) begin
      estado      <= BUSCA;
      pc          <= alvoDesvio;
      memReq      <= 1'b1;
      saidaValida <= 1'b0;
    end else begin
      case (estado)
        BUSCA: begin
          if (memReq && memPronto) begin
            ir          <= memDado;
            pcInstrucao <= pc;
            pc          <= pc + 1'b1;
            estado      <= ENTREGA;
            memReq      <= 1'b0;
            saidaValida <= 1'b1;
          end else begin
            memReq      <= 1'b1;
            saidaValida <= 1'b0;
          end
        end
        ENTREGA: begin
          if (saidaPronta) begin
            estado      <= is_halt(ir) ? PARADO : BUSCA;
            memReq      <= !is_halt(ir);
            saidaValida <= 1'b0;
          end
        end
        PARADO: begin
          memReq      <= 1'b0;
          saidaValida <= 1'b0;
        end
        default: begin
          estado      <= BUSCA;
          memReq      <= 1'b0;
          saidaValida <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb/tb_instr_fetch_decode.sv - directed self-checking bench for instr_fetch_decode
module tb_instr_fetch_decode;

  logic       clock = 1'b0;
  logic       reset;
  logic       memReq;
  logic [7:0] memEndereco;
  logic [7:0] memDado;
  logic       memPronto;
  logic       saidaValida;
  logic       saidaPronta;
  logic [2:0] opcode;
  logic [1:0] regDestino;
  logic [2:0] imediato;
  logic [7:0] pcInstrucao;
  logic       desvio;
  logic [7:0] alvoDesvio;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  instr_fetch_decode #(.LARGURA_PC(8), .PC_RESET(8'h00)) dut (
    .clock(clock), .reset(reset),
    .memReq(memReq), .memEndereco(memEndereco), .memDado(memDado), .memPronto(memPronto),
    .saidaValida(saidaValida), .saidaPronta(saidaPronta),
    .opcode(opcode), .regDestino(regDestino), .imediato(imediato), .pcInstrucao(pcInstrucao),
    .desvio(desvio), .alvoDesvio(alvoDesvio)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; memDado = 8'h00; memPronto = 1'b0; saidaPronta = 1'b0;
    desvio = 1'b0; alvoDesvio = 8'h00;
    step(); step();
    n_cmp++; if (memReq !== 1'b0) begin n_err++; $display("FAIL rst_memReq got=%b exp=0", memReq); end
    n_cmp++; if (saidaValida !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", saidaValida); end
    n_cmp++; if ({opcode, regDestino, imediato} !== 8'h00) begin n_err++; $display("FAIL rst_fields got=%h exp=00", {opcode, regDestino, imediato}); end
    n_cmp++; if (memEndereco !== 8'h00) begin n_err++; $display("FAIL rst_addr got=%h exp=00", memEndereco); end
    n_cmp++; if (pcInstrucao !== 8'h00) begin n_err++; $display("FAIL rst_pcinstr got=%h exp=00", pcInstrucao); end
    reset = 1'b1;
    step();
    n_cmp++; if (memReq !== 1'b1) begin n_err++; $display("FAIL first_req got=%b exp=1", memReq); end
    n_cmp++; if (memEndereco !== 8'h00) begin n_err++; $display("FAIL first_addr got=%h exp=00", memEndereco); end
  endtask

  task automatic test_fetch_basic();
    memPronto = 1'b1; memDado = 8'h4A;
    step();
    memPronto = 1'b0;
    n_cmp++; if (saidaValida !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b exp=1", saidaValida); end
    n_cmp++; if (opcode !== 3'b010) begin n_err++; $display("FAIL basic_opcode got=%b exp=010", opcode); end
    n_cmp++; if (regDestino !== 2'b01) begin n_err++; $display("FAIL basic_reg got=%b exp=01", regDestino); end
    n_cmp++; if (imediato !== 3'b010) begin n_err++; $display("FAIL basic_imm got=%b exp=010", imediato); end
    n_cmp++; if (pcInstrucao !== 8'h00) begin n_err++; $display("FAIL basic_pcinstr got=%h exp=00", pcInstrucao); end
    n_cmp++; if (memEndereco !== 8'h01) begin n_err++; $display("FAIL basic_pc got=%h exp=01", memEndereco); end
    n_cmp++; if (memReq !== 1'b0) begin n_err++; $display("FAIL basic_noreq got=%b exp=0", memReq); end
    saidaPronta = 1'b1;
    step();
    saidaPronta = 1'b0;
    n_cmp++; if ({memReq, saidaValida} !== 2'b10) begin n_err++; $display("FAIL basic_back_busca got=%b exp=10", {memReq, saidaValida}); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if ({memReq, saidaValida, memEndereco} !== {2'b10, 8'h01}) begin n_err++; $display("FAIL wait_hold[%0d] got=%b/%b/%h exp=1/0/01", i, memReq, saidaValida, memEndereco); end
    end
    memPronto = 1'b1; memDado = 8'h25;
    step();
    memPronto = 1'b0;
    n_cmp++; if ({saidaValida, opcode, regDestino, imediato} !== {1'b1, 3'b001, 2'b00, 3'b101}) begin n_err++; $display("FAIL wait_decode got=%b/%b/%b/%b exp=1/001/00/101", saidaValida, opcode, regDestino, imediato); end
    n_cmp++; if (pcInstrucao !== 8'h01) begin n_err++; $display("FAIL wait_pcinstr got=%h exp=01", pcInstrucao); end
  endtask

  task automatic test_backpressure();
    saidaPronta = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if ({saidaValida, memReq, opcode, imediato, pcInstrucao, memEndereco} !== {1'b1, 1'b0, 3'b001, 3'b101, 8'h01, 8'h02})
        begin n_err++; $display("FAIL bp_hold[%0d] got=%b/%b/%b/%b/%h/%h exp=1/0/001/101/01/02", i, saidaValida, memReq, opcode, imediato, pcInstrucao, memEndereco); end
    end
    saidaPronta = 1'b1;
    step();
    saidaPronta = 1'b0;
    n_cmp++; if ({memReq, saidaValida, memEndereco} !== {2'b10, 8'h02}) begin n_err++; $display("FAIL bp_release got=%b/%b/%h exp=1/0/02", memReq, saidaValida, memEndereco); end
  endtask

  task automatic test_branch_with_data();
    memPronto = 1'b1; memDado = 8'h11; desvio = 1'b1; alvoDesvio = 8'h80;
    step();
    memPronto = 1'b0; desvio = 1'b0;
    n_cmp++; if ({memReq, saidaValida, memEndereco} !== {2'b10, 8'h80}) begin n_err++; $display("FAIL br_redirect got=%b/%b/%h exp=1/0/80", memReq, saidaValida, memEndereco); end
    n_cmp++; if ({opcode, regDestino, imediato} !== 8'h25) begin n_err++; $display("FAIL br_ir_kept got=%h exp=25", {opcode, regDestino, imediato}); end
    step();
    n_cmp++; if (saidaValida !== 1'b0) begin n_err++; $display("FAIL br_never_valid got=%b exp=0", saidaValida); end
  endtask

  task automatic test_halt();
    memPronto = 1'b1; memDado = 8'hFF;
    step();
    memPronto = 1'b0;
    n_cmp++; if ({saidaValida, opcode, pcInstrucao} !== {1'b1, 3'b111, 8'h80}) begin n_err++; $display("FAIL halt_present got=%b/%b/%h exp=1/111/80", saidaValida, opcode, pcInstrucao); end
    saidaPronta = 1'b1;
    step();
    saidaPronta = 1'b0;
    memPronto = 1'b1; memDado = 8'h33;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({memReq, saidaValida, memEndereco} !== {2'b00, 8'h81}) begin n_err++; $display("FAIL halt_parked[%0d] got=%b/%b/%h exp=0/0/81", i, memReq, saidaValida, memEndereco); end
      step();
    end
    memPronto = 1'b0;
    desvio = 1'b1; alvoDesvio = 8'h10;
    step();
    desvio = 1'b0;
    n_cmp++; if ({memReq, memEndereco} !== {1'b1, 8'h10}) begin n_err++; $display("FAIL halt_resume got=%b/%h exp=1/10", memReq, memEndereco); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr [3];
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00;
    desvio = 1'b1; alvoDesvio = 8'hFE;
    step();
    desvio = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({memReq, memEndereco} !== {1'b1, exp_addr[i]}) begin n_err++; $display("FAIL wrap_addr[%0d] got=%b/%h exp=1/%h", i, memReq, memEndereco, exp_addr[i]); end
      memPronto = 1'b1; memDado = 8'h40 + 8'(i);
      step();
      memPronto = 1'b0;
      n_cmp++; if ({saidaValida, pcInstrucao} !== {1'b1, exp_addr[i]}) begin n_err++; $display("FAIL wrap_pcinstr[%0d] got=%b/%h exp=1/%h", i, saidaValida, pcInstrucao, exp_addr[i]); end
      n_cmp++; if ($isunknown({memReq, memEndereco, saidaValida, opcode, regDestino, imediato, pcInstrucao})) begin n_err++; $display("FAIL wrap_noX[%0d] got=X exp=known", i); end
      saidaPronta = 1'b1;
      step();
      saidaPronta = 1'b0;
    end
  endtask

  task automatic test_branch_drop();
    memPronto = 1'b1; memDado = 8'hA3;
    step();
    memPronto = 1'b0;
    n_cmp++; if ({saidaValida, pcInstrucao} !== {1'b1, 8'h01}) begin n_err++; $display("FAIL drop_present got=%b/%h exp=1/01", saidaValida, pcInstrucao); end
    desvio = 1'b1; alvoDesvio = 8'h33;
    step();
    desvio = 1'b0;
    n_cmp++; if ({saidaValida, memReq, memEndereco} !== {2'b01, 8'h33}) begin n_err++; $display("FAIL drop_redirect got=%b/%b/%h exp=0/1/33", saidaValida, memReq, memEndereco); end
  endtask

  task automatic test_reset_midfetch();
    reset = 1'b0; memPronto = 1'b1; memDado = 8'hE7;
    step();
    reset = 1'b1; memPronto = 1'b0;
    n_cmp++; if ({memReq, saidaValida, opcode, regDestino, imediato} !== 10'b0) begin n_err++; $display("FAIL midrst_clear got=%b/%b/%h exp=0/0/00", memReq, saidaValida, {opcode, regDestino, imediato}); end
    n_cmp++; if ({memEndereco, pcInstrucao} !== 16'h0000) begin n_err++; $display("FAIL midrst_pc got=%h/%h exp=00/00", memEndereco, pcInstrucao); end
    step();
    n_cmp++; if ({memReq, memEndereco} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL midrst_restart got=%b/%h exp=1/00", memReq, memEndereco); end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_wait_states();
    test_backpressure();
    test_branch_with_data();
    test_halt();
    test_wrap();
    test_branch_drop();
    test_reset_midfetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Fetch/decode front end of the 8-bit processor. Sits directly upstream of the 3-to-8 sign extender and the register file.
- Holds the program counter and fetches 8-bit instruction words over a request/ready memory handshake.
- Latches each word into an instruction register and presents its decoded fields to downstream with a valid/ready handshake. The 3-bit immediate field is the extender's input.
- Handles branch redirects and a HALT instruction.

Parameters:
- LARGURA_PC, 8, program counter and memory address width.
- PC_RESET, 8'h00, PC value loaded on reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- memReq  out  1  instruction memory read request.
- memEndereco  out  LARGURA_PC  fetch address.
- memDado  in  8  instruction word; valid when memPronto=1.
- memPronto  in  1  memory returns data this cycle.
- saidaValida  out  1  decoded instruction available.
- saidaPronta  in  1  downstream accepts the instruction this cycle.
- opcode  out  3  instruction register bits [7:5].
- regDestino  out  2  instruction register bits [4:3].
- imediato  out  3  instruction register bits [2:0]; drives the sign extender.
- pcInstrucao  out  LARGURA_PC  address of the presented instruction.
- desvio  in  1  branch redirect request.
- alvoDesvio  in  LARGURA_PC  branch target.

Behaviour:
- Reset: sampled on the rising clock edge while reset=0.
  - pc=PC_RESET, instruction register=0, pcInstrucao=0, state=BUSCA.
  - While reset is held: memReq=0, saidaValida=0, opcode/regDestino/imediato=0, memEndereco=PC_RESET.
  - First memReq=1 appears in the first cycle after reset deasserts.
  - Reset asserted mid-fetch abandons the fetch; a memPronto arriving in that cycle is ignored.
- State machine (Moore outputs; memEndereco=pc at all times):
  - BUSCA: memReq=1, saidaValida=0. Memory may hold memPronto=0 for any number of cycles (wait states). On memPronto=1: instruction register<=memDado, pcInstrucao<=pc, pc<=pc+1 (modulo 2^LARGURA_PC, 8'hFF wraps to 8'h00), next state ENTREGA.
  - ENTREGA: memReq=0, saidaValida=1. Fields are stable until accepted. On saidaPronta=1: if the instruction register equals HALT (8'hFF), next state PARADO; otherwise next state BUSCA. On saidaPronta=0: stay in ENTREGA with outputs unchanged (backpressure).
  - PARADO: memReq=0, saidaValida=0. Leaves only on reset or desvio.
- desvio=1 has priority over everything except reset, in every state:
  - pc<=alvoDesvio and next state BUSCA.
  - A memPronto in the same cycle is discarded; the instruction register is not loaded.
  - In ENTREGA with saidaPronta=1 in the same cycle, the handshake still completes (the instruction is consumed), then fetch resumes at alvoDesvio.
  - In ENTREGA with saidaPronta=0, the pending instruction is dropped; saidaValida=0 next cycle.
  - desvio=1 in PARADO restarts fetching.
- Throughput: at most one instruction per 2 cycles. Fetch-to-valid latency is 1 cycle after the memPronto edge.
- The block does no field interpretation beyond HALT detection. Opcode semantics belong downstream.

Decomposition:
- Shared package nrisk_pkg holds:
  - field bit positions: OPCODE [7:5], REG [4:3], IMM [2:0];
  - the opcode constants and the HALT word 8'hFF;
  - the state encoding, 2 bits: BUSCA=0, ENTREGA=1, PARADO=2.
- No sub-module. The sign extender is instantiated beside this block by the parent datapath, fed from imediato.

Test Plan:
- Reset low 2 cycles, then high; memory returns 8'h4A with zero wait -> cycle 1: memReq=1, memEndereco=00. Next cycle: saidaValida=1, opcode=010, regDestino=01, imediato=010, pcInstrucao=00; pc=01.
- Memory holds memPronto=0 for 3 cycles, then returns 8'h25 -> memReq stays 1 and memEndereco stays constant the whole time; one valid output with opcode=001, imediato=101.
- saidaPronta=0 for 4 cycles in ENTREGA -> saidaValida and all fields held, memReq=0, pc unchanged; saidaPronta=1 -> return to BUSCA at the next address.
- desvio=1, alvoDesvio=8'h80 in the same cycle as memPronto=1 (data 8'h11) -> 8'h11 never presented; next request at memEndereco=80.
- Fetch 8'hFF, accept it -> state PARADO, memReq=0 indefinitely; then desvio with alvoDesvio=8'h10 -> fetching resumes at 10.
- Start at pc=8'hFE (via desvio) -> successive fetches at FE, FF, 00; pcInstrucao reports FE, FF, 00; no X on any output.
